traceback_unit: RTL

TRACEBACK_UNIT -- requirements
Module: traceback_unit

---
 rtl/vit_pkg.sv | 16 +
 rtl/tb_mem.sv | 25 ++
 rtl/traceback_unit.sv | 127 ++++++++++++
 3 files changed

// File: rtl/vit_pkg.sv
// Shared Viterbi traceback definitions: default sizing, FSM encoding and decision-word type.
package vit_pkg;

    localparam int VIT_NUM_STATES = 4;
    localparam int VIT_MAX_FRAME  = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_TRACE  = 2'd2,
        ST_OUTPUT = 2'd3
    } tb_state_t;

    typedef logic [VIT_NUM_STATES-1:0] dec_word_t;

endpackage

// File: rtl/tb_mem.sv
// Survivor memory: one decision word per symbol, synchronous write, combinational read, no reset.
module tb_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/traceback_unit.sv
// Viterbi traceback: buffers a frame of ACS decisions, traces back from the end state,
// then streams the decoded bits out first-transmitted first.
module traceback_unit
    import vit_pkg::*;
#(
    parameter int NUM_STATES = VIT_NUM_STATES,
    parameter int MAX_FRAME  = VIT_MAX_FRAME
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dec_valid,
    input  logic [NUM_STATES-1:0] dec_bits,
    input  logic                  dec_last,
    input  logic [1:0]            end_state,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic                  out_bit,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic                  overflow,
    output logic [1:0]            dbg_state
);

    localparam int AW = $clog2(MAX_FRAME);
    localparam int PW = AW + 1;

    tb_state_t               r_state;
    logic [PW-1:0]           r_wr_ptr;
    logic [PW-1:0]           r_rd_ptr;
    logic [PW-1:0]           r_tr_ptr;
    logic [PW-1:0]           r_len;
    logic [1:0]              r_cur_state;
    logic                    r_overflow;
    logic [MAX_FRAME-1:0]    r_obuf;

    logic                    w_accept;
    logic                    w_at_max;
    logic                    w_out_end;
    logic [NUM_STATES-1:0]   w_rd_word;

    // Handshakes: a word moves when dec_valid && in_ready at a rising edge; a bit moves when
    // out_valid && out_ready. Both sides hold their data until that edge.
    assign in_ready  = (r_state == ST_IDLE) || (r_state == ST_WRITE);
    assign w_accept  = dec_valid && in_ready;
    assign w_at_max  = (r_wr_ptr == PW'(MAX_FRAME - 1));
    assign w_out_end = (r_rd_ptr == r_len - PW'(1));

    assign out_valid = (r_state == ST_OUTPUT);
    assign out_last  = (r_state == ST_OUTPUT) && w_out_end;
    assign out_bit   = (r_state == ST_OUTPUT) ? r_obuf[r_rd_ptr[AW-1:0]] : 1'b0;
    assign overflow  = r_overflow;
    assign dbg_state = r_state;

    tb_mem #(
        .DEPTH (MAX_FRAME),
        .WIDTH (NUM_STATES)
    ) u_tb_mem (
        .clk     (clk),
        .i_we    (w_accept),
        .i_waddr (r_wr_ptr[AW-1:0]),
        .i_wdata (dec_bits),
        .i_raddr (r_tr_ptr[AW-1:0]),
        .o_rdata (w_rd_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_tr_ptr    <= '0;
            r_len       <= '0;
            r_cur_state <= '0;
            r_overflow  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_WRITE: begin
                    if (dec_valid) begin
                        if (r_state == ST_IDLE) begin
                            r_overflow <= 1'b0;
                        end
                        // A full buffer without dec_last closes the frame from state 0.
                        if (dec_last || w_at_max) begin
                            r_len       <= r_wr_ptr + PW'(1);
                            r_tr_ptr    <= r_wr_ptr;
                            r_cur_state <= dec_last ? end_state : 2'b00;
                            r_overflow  <= !dec_last;
                            r_wr_ptr    <= '0;
                            r_state     <= ST_TRACE;
                        end else begin
                            r_wr_ptr <= r_wr_ptr + PW'(1);
                            r_state  <= ST_WRITE;
                        end
                    end
                end
                ST_TRACE: begin
                    r_cur_state <= {r_cur_state[0], w_rd_word[r_cur_state]};
                    if (r_tr_ptr == '0) begin
                        r_rd_ptr <= '0;
                        r_state  <= ST_OUTPUT;
                    end else begin
                        r_tr_ptr <= r_tr_ptr - PW'(1);
                    end
                end
                ST_OUTPUT: begin
                    if (out_ready) begin
                        if (w_out_end) begin
                            r_rd_ptr <= '0;
                            r_state  <= ST_IDLE;
                        end else begin
                            r_rd_ptr <= r_rd_ptr + PW'(1);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // The MSB of the traced state is the input bit that entered at that symbol.
    always_ff @(posedge clk) begin
        if (r_state == ST_TRACE) begin
            r_obuf[r_tr_ptr[AW-1:0]] <= r_cur_state[1];
        end
    end

endmodule
